// File: rtl/cnn_mac_engine.sv
// ---------------------------------------------------------------------------
// cnn_mac_engine
//   Multiply-accumulate engine for one CNN layer slice. A frame of NUM_IN
//   input elements streams in one element per beat. Every element is
//   multiplied by a per-channel weight and summed into NUM_CH accumulators
//   in parallel. When the frame is complete, the NUM_CH results are drained
//   one channel per handshake, after optional ReLU and saturation to OUT_W.
//
// Ports
//   Clk       in   clock, rising edge
//   Rst       in   asynchronous active-high reset
//   In_Valid  in   input beat valid
//   In_Ready  out  engine accepts a beat (accumulate phase)
//   In_Data   in   [DATA_W-1:0]        input element
//   W_Data    in   [NUM_CH*DATA_W-1:0] channel c weight at [c*DATA_W +: DATA_W]
//   Out_Valid out  result valid (drain phase)
//   Out_Ready in   consumer accepts the result
//   Out_Data  out  [OUT_W-1:0]         channel result
//   Out_Ch    out  channel index of Out_Data
//   Out_Last  out  final channel of the frame
// ---------------------------------------------------------------------------
module cnn_mac_engine #(
  parameter int DATA_W  = 8,
  parameter int NUM_IN  = 16,
  parameter int NUM_CH  = 4,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 16,
  parameter int SIGNED  = 0,
  parameter int RELU_EN = 0,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [DATA_W-1:0]        In_Data,
  input  logic [NUM_CH*DATA_W-1:0] W_Data,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [OUT_W-1:0]         Out_Data,
  output logic [CH_W-1:0]          Out_Ch,
  output logic                     Out_Last
);

  localparam int CNT_W  = $clog2(NUM_IN);
  localparam int PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [ACC_W-1:0]  acc_q [NUM_CH];
  logic signed [ACC_W-1:0]  acc_d [NUM_CH];

  // Full-precision product, sign- or zero-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_prod(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] w);
    logic signed [PROD_W-1:0] ps;
    logic [PROD_W-1:0]        pu;
    if (SIGNED != 0) begin
      ps = $signed(a) * $signed(w);
      return $signed({{(ACC_W-PROD_W){ps[PROD_W-1]}}, ps});
    end else begin
      pu = a * w;
      return $signed({{(ACC_W-PROD_W){1'b0}}, pu});
    end
  endfunction

  // ReLU (signed mode only) followed by clamping into OUT_W.
  function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    logic [ACC_W-1:0]        u;
    if (SIGNED != 0) begin
      r = ((RELU_EN != 0) && (v < 0)) ? '0 : v;
      if (r > S_MAX)      return {1'b0, {(OUT_W-1){1'b1}}};
      else if (r < S_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
      else                return r[OUT_W-1:0];
    end else begin
      u = v;
      if (|u[ACC_W-1:OUT_W]) return '1;
      else                   return u[OUT_W-1:0];
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    for (int c = 0; c < NUM_CH; c++) acc_d[c] = acc_q[c];
    case (state_q)
      S_ACC: begin
        if (In_Valid) begin
          for (int c = 0; c < NUM_CH; c++)
            acc_d[c] = acc_q[c] + mac_prod(In_Data, W_Data[c*DATA_W +: DATA_W]);
          if (cnt_q == CNT_W'(NUM_IN - 1)) begin
            cnt_d   = '0;
            ch_d    = '0;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_OUT: begin
        if (Out_Ready) begin
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            // Last channel taken: clear for the next frame.
            ch_d    = '0;
            state_d = S_ACC;
            for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_ACC;
      cnt_q   <= '0;
      ch_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign In_Ready  = (state_q == S_ACC);
  assign Out_Valid = (state_q == S_OUT);
  assign Out_Ch    = ch_q;
  assign Out_Last  = Out_Valid && (ch_q == CH_W'(NUM_CH - 1));
  // Data is forced to zero outside the drain phase so idle/reset output is 0.
  assign Out_Data  = Out_Valid ? sat_out(acc_q[ch_q]) : '0;

endmodule

// File: doc/cnn_mac_engine.md
CNN_MAC_ENGINE -- requirements
Module: cnn_mac_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, input/weight element width.
REQ-002 The block SHALL have parameter NUM_IN, default 16, elements per frame (>=2).
REQ-003 The block SHALL have parameter NUM_CH, default 4, output channels (>=1).
REQ-004 The block SHALL have parameter ACC_W, default 24, accumulator width, >= 2*DATA_W+clog2(NUM_IN).
REQ-005 The block SHALL have parameter OUT_W, default 16, result width (< ACC_W).
REQ-006 The block SHALL have parameter SIGNED, default 0; 1 means In_Data, W_Data and results are two's complement.
REQ-007 The block SHALL have parameter RELU_EN, default 0; 1 means negative results clamp to 0 (effective only with SIGNED=1).
REQ-008 The block SHALL have port Clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-009 The block SHALL have port Rst, input, 1, reset, asynchronous, active-high.
REQ-010 The block SHALL have port In_Valid, input, 1, input beat valid.
REQ-011 The block SHALL have port In_Ready, output, 1, block accepts an input beat.
REQ-012 The block SHALL have port In_Data, input, DATA_W, one input element.
REQ-013 The block SHALL have port W_Data, input, NUM_CH*DATA_W, channel c weight in bits [c*DATA_W +: DATA_W].
REQ-014 The block SHALL have port Out_Valid, output, 1, result valid.
REQ-015 The block SHALL have port Out_Ready, input, 1, consumer accepts the result.
REQ-016 The block SHALL have port Out_Data, output, OUT_W, channel result.
REQ-017 The block SHALL have port Out_Ch, output, clog2(NUM_CH) (min 1), channel index of Out_Data.
REQ-018 The block SHALL have port Out_Last, output, 1, high with the final channel of a frame.

Function
REQ-019 The block SHALL implement an FSM with states ACC and OUT; reset state is ACC.
REQ-020 In ACC, In_Ready SHALL be 1 and Out_Valid 0; in OUT, In_Ready SHALL be 0 and Out_Valid 1.
REQ-021 The block SHALL accept a beat only when In_Valid&&In_Ready; beats with In_Valid=0 leave counter and accumulators unchanged.
REQ-022 On each accepted beat, acc[c] SHALL be updated to acc[c]+In_Data*W_Data[c] for every c in parallel, full-precision product sign/zero-extended to ACC_W per SIGNED.
REQ-023 Beat counter SHALL count 0..NUM_IN-1; acceptance at NUM_IN-1 SHALL update acc, reset counter to 0, set channel index 0 and enter OUT on the same edge.
REQ-024 Out_Valid SHALL rise in the cycle immediately after the final beat is accepted (1-cycle latency).
REQ-025 In OUT, Out_Data SHALL be the result for acc[Out_Ch] after ReLU (if RELU_EN&&SIGNED) then saturation.
REQ-026 Saturation SHALL clamp unsigned results to 2^OUT_W-1 and signed results to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; in-range values pass unchanged.
REQ-027 Out_Data, Out_Ch and Out_Last SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-028 On an Out_Valid&&Out_Ready handshake, Out_Ch SHALL increment; at NUM_CH-1 all accumulators SHALL clear to 0 and the FSM SHALL return to ACC on the same edge.
REQ-029 With NUM_CH=1, Out_Last SHALL be 1 on every result.
REQ-030 Accumulators SHALL never wrap within one frame given REQ-004.

Reset
REQ-031 Rst=1 SHALL asynchronously force state ACC, counter 0, Out_Ch 0 and all acc 0, with In_Ready=1, Out_Valid=0, Out_Data=0 and Out_Last=0.
REQ-032 Rst asserted mid-frame or mid-drain SHALL discard the partial frame; the first frame after release SHALL be computed only from beats accepted after release.

Verification
REQ-033 The bench SHALL cover: defaults, In_Data=1..16, all weights 1 -> 4 results of 136, Out_Ch 0..3, Out_Last on ch 3.
REQ-034 The bench SHALL cover: defaults, In_Data=255, weights 255 -> acc 1040400 -> Out_Data=65535 on all channels.
REQ-035 The bench SHALL cover: SIGNED=1, In_Data=0xFF (-1), weights 1 -> RELU_EN=0 gives 0xFFF0; RELU_EN=1 gives 0.
REQ-036 The bench SHALL cover: Out_Ready low 3 cycles at ch 1 -> Out_Data/Out_Ch held; In_Ready stays 0; no channel skipped.
REQ-037 The bench SHALL cover: In_Valid toggled every other cycle over 16 beats -> same 136 result; Out_Valid exactly one cycle after beat 16.
REQ-038 The bench SHALL cover: Rst after 5 beats, then full 1..16/weight-1 frame -> results 136, not contaminated.
